// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - store/load/fetch arbiter for the unified memory port with read-owner tag pipeline.
// Optional fetch anti-starvation aging is enabled by defining MEM_ARB_AGING_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              st_grant,
  output logic              ld_grant,
  output logic              if_grant,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rsp_data,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_starved,
  output logic [1:0]        mem_command,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_LD   = 2'd1,
    TAG_IF   = 2'd2
  } tag_t;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must fit the 3-bit aging counter (1..7)");
    end
  endgenerate

  logic if_eligible;
  logic starved;
  tag_t tags [MEM_LATENCY];
  tag_t last_tag;

  assign if_eligible = if_req & ~if_flush;

`ifdef MEM_ARB_AGING_EN
  localparam logic [2:0] STARVE_CNT = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  // Saturating count of cycles an eligible fetch lost arbitration.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (if_grant || if_flush) begin
      starve_cnt <= 3'd0;
    end else if (if_eligible && starve_cnt != 3'd7) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign starved = ~reset & (starve_cnt >= STARVE_CNT);
`else
  assign starved = 1'b0;
`endif

  assign if_starved = starved;

  always_comb begin
    st_grant = 1'b0;
    ld_grant = 1'b0;
    if_grant = 1'b0;
    if (!reset) begin
      if (starved && if_eligible) begin
        if_grant = 1'b1;
      end else if (st_req) begin
        st_grant = 1'b1;
      end else if (ld_req) begin
        ld_grant = 1'b1;
      end else if (if_eligible) begin
        if_grant = 1'b1;
      end
    end
  end

  always_comb begin
    mem_command = CMD_NONE;
    mem_addr    = '0;
    mem_size    = 2'd0;
    mem_wdata   = '0;
    if (st_grant) begin
      mem_command = CMD_STORE;
      mem_addr    = st_addr;
      mem_size    = st_size;
      mem_wdata   = st_data;
    end else if (ld_grant) begin
      mem_command = CMD_LOAD;
      mem_addr    = ld_addr;
      mem_size    = ld_size;
    end else if (if_grant) begin
      mem_command = CMD_LOAD;
      mem_addr    = if_addr;
      mem_size    = SIZE_DOUBLE;
    end
  end

  // Owner of each in-flight read; a flush kills fetch tags as they advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tags[i] <= TAG_NONE;
      end
    end else begin
      tags[0] <= ld_grant ? TAG_LD : (if_grant ? TAG_IF : TAG_NONE);
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tags[i] <= (if_flush && tags[i-1] == TAG_IF) ? TAG_NONE : tags[i-1];
      end
    end
  end

  assign last_tag     = tags[MEM_LATENCY-1];
  assign ld_rsp_valid = ~reset & (last_tag == TAG_LD);
  assign if_rsp_valid = ~reset & ~if_flush & (last_tag == TAG_IF);
  assign ld_rsp_data  = ld_rsp_valid ? mem_rdata : '0;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_req, ld_req, if_req, if_flush;
  logic [31:0] st_addr, ld_addr, if_addr;
  logic [63:0] st_data, mem_rdata;
  logic [1:0]  st_size, ld_size;
  logic        st_grant, ld_grant, if_grant;
  logic        ld_rsp_valid, if_rsp_valid, if_starved;
  logic [63:0] ld_rsp_data, if_rsp_data, mem_wdata;
  logic [1:0]  mem_command, mem_size;
  logic [31:0] mem_addr;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .st_grant(st_grant), .ld_grant(ld_grant), .if_grant(if_grant),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_starved(if_starved), .mem_command(mem_command), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    st_req = 0; ld_req = 0; if_req = 0; if_flush = 0;
    st_addr = 0; ld_addr = 0; if_addr = 0; st_data = 0; mem_rdata = 0;
    st_size = 0; ld_size = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    st_req = 1; ld_req = 1; if_req = 1; st_data = 64'h55; st_addr = 32'h40;
    step(); step(); settle();
    tests++; if ({st_grant, ld_grant, if_grant} !== 3'b000) begin fails++; $display("FAIL reset_grants: got %b want 000", {st_grant, ld_grant, if_grant}); end
    tests++; if (mem_command !== 2'd0) begin fails++; $display("FAIL reset_cmd: got %0d want 0", mem_command); end
    tests++; if ({ld_rsp_valid, if_rsp_valid, if_starved} !== 3'b000) begin fails++; $display("FAIL reset_valids: got %b want 000", {ld_rsp_valid, if_rsp_valid, if_starved}); end
    tests++; if (mem_wdata !== 64'h0 || mem_addr !== 32'h0) begin fails++; $display("FAIL reset_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    idle_inputs();
    step();
    reset = 0;
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100; settle();
    tests++; if (if_grant !== 1'b1 || mem_command !== 2'd1) begin fails++; $display("FAIL fetch_grant: got grant %b cmd %0d want 1 1", if_grant, mem_command); end
    tests++; if (mem_addr !== 32'h100 || mem_size !== 2'd3) begin fails++; $display("FAIL fetch_bus: got addr %h size %0d want 100 3", mem_addr, mem_size); end
    step(); if_req = 0; settle();
    tests++; if (if_rsp_valid !== 1'b0) begin fails++; $display("FAIL fetch_early: got %b want 0", if_rsp_valid); end
    step(); mem_rdata = 64'hDEAD; settle();
    tests++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'hDEAD) begin fails++; $display("FAIL fetch_rsp: got v %b d %h want 1 dead", if_rsp_valid, if_rsp_data); end
    tests++; if (ld_rsp_valid !== 1'b0 || ld_rsp_data !== 64'h0) begin fails++; $display("FAIL fetch_ld_quiet: got v %b d %h want 0 0", ld_rsp_valid, ld_rsp_data); end
    step(); settle();
    tests++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 64'h0) begin fails++; $display("FAIL fetch_after: got v %b d %h want 0 0", if_rsp_valid, if_rsp_data); end
    mem_rdata = 0;
  endtask

  task automatic test_priority();
    st_req = 1; st_addr = 32'h200; st_data = 64'h1122334455667788; st_size = 2'd2;
    ld_req = 1; ld_addr = 32'h300; ld_size = 2'd1;
    if_req = 1; if_addr = 32'h400; settle();
    tests++; if ({st_grant, ld_grant, if_grant} !== 3'b100 || mem_command !== 2'd2) begin fails++; $display("FAIL prio_store: got %b cmd %0d want 100 2", {st_grant, ld_grant, if_grant}, mem_command); end
    tests++; if (mem_wdata !== 64'h1122334455667788 || mem_addr !== 32'h200 || mem_size !== 2'd2) begin fails++; $display("FAIL prio_store_bus: got %h %h %0d", mem_wdata, mem_addr, mem_size); end
    step(); st_req = 0; settle();
    tests++; if ({st_grant, ld_grant, if_grant} !== 3'b010 || mem_command !== 2'd1) begin fails++; $display("FAIL prio_load: got %b cmd %0d want 010 1", {st_grant, ld_grant, if_grant}, mem_command); end
    tests++; if (mem_addr !== 32'h300 || mem_size !== 2'd1 || mem_wdata !== 64'h0) begin fails++; $display("FAIL prio_load_bus: got %h %0d %h", mem_addr, mem_size, mem_wdata); end
    step(); ld_req = 0; settle();
    tests++; if ({st_grant, ld_grant, if_grant} !== 3'b001) begin fails++; $display("FAIL prio_fetch: got %b want 001", {st_grant, ld_grant, if_grant}); end
    tests++; if (ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL store_no_rsp: got %b want 0", ld_rsp_valid); end
    step(); if_req = 0; settle();
    tests++; if (ld_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin fails++; $display("FAIL prio_ld_rsp: got ld %b if %b want 1 0", ld_rsp_valid, if_rsp_valid); end
    step(); step();
  endtask

  task automatic test_back_to_back();
    ld_req = 1; ld_addr = 32'hA0; settle();
    tests++; if (ld_grant !== 1'b1) begin fails++; $display("FAIL b2b_grant0: got %b want 1", ld_grant); end
    step(); ld_addr = 32'hB0; settle();
    tests++; if (ld_grant !== 1'b1 || ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_grant1: got g %b v %b want 1 0", ld_grant, ld_rsp_valid); end
    step(); ld_req = 0; mem_rdata = 64'hAAAA; settle();
    tests++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 64'hAAAA) begin fails++; $display("FAIL b2b_rsp_a: got v %b d %h want 1 aaaa", ld_rsp_valid, ld_rsp_data); end
    step(); mem_rdata = 64'hBBBB; settle();
    tests++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 64'hBBBB) begin fails++; $display("FAIL b2b_rsp_b: got v %b d %h want 1 bbbb", ld_rsp_valid, ld_rsp_data); end
    step(); mem_rdata = 0; settle();
    tests++; if (ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_done: got %b want 0", ld_rsp_valid); end
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h500; settle();
    tests++; if (if_grant !== 1'b1) begin fails++; $display("FAIL flush_fetch_grant: got %b want 1", if_grant); end
    step(); if_flush = 1; ld_req = 1; ld_addr = 32'h600; settle();
    tests++; if (ld_grant !== 1'b1 || if_grant !== 1'b0) begin fails++; $display("FAIL flush_ld_grant: got ld %b if %b want 1 0", ld_grant, if_grant); end
    step(); if_flush = 0; ld_req = 0; if_req = 0; mem_rdata = 64'h1111; settle();
    tests++; if (if_rsp_valid !== 1'b0 || ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_killed: got if %b ld %b want 0 0", if_rsp_valid, ld_rsp_valid); end
    step(); mem_rdata = 64'h2222; settle();
    tests++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 64'h2222 || if_rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_ld_rsp: got v %b d %h if %b", ld_rsp_valid, ld_rsp_data, if_rsp_valid); end
    step(); mem_rdata = 0;
    if_req = 1; if_flush = 1; settle();
    tests++; if (if_grant !== 1'b0 || mem_command !== 2'd0) begin fails++; $display("FAIL flush_blocks_fetch: got g %b cmd %0d want 0 0", if_grant, mem_command); end
    if_flush = 0; settle();
    step(); if_req = 0; step(); if_flush = 1; mem_rdata = 64'h3333; settle();
    tests++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 64'h0) begin fails++; $display("FAIL flush_last_stage: got v %b d %h want 0 0", if_rsp_valid, if_rsp_data); end
    step(); if_flush = 0; mem_rdata = 0; settle();
    tests++; if (if_rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_gone: got %b want 0", if_rsp_valid); end
  endtask

  task automatic test_aging();
    ld_req = 1; if_req = 1; ld_addr = 32'h700; if_addr = 32'h800;
    for (int c = 0; c < 4; c++) begin
      settle();
      tests++; if (ld_grant !== 1'b1 || if_starved !== 1'b0) begin fails++; $display("FAIL aging_pre%0d: got ld %b starved %b want 1 0", c, ld_grant, if_starved); end
      step();
    end
    settle();
`ifdef MEM_ARB_AGING_EN
    tests++; if (if_starved !== 1'b1 || if_grant !== 1'b1 || ld_grant !== 1'b0) begin fails++; $display("FAIL aging_promote: got s %b if %b ld %b want 1 1 0", if_starved, if_grant, ld_grant); end
    step(); if_req = 0; settle();
    tests++; if (ld_grant !== 1'b1 || if_starved !== 1'b0) begin fails++; $display("FAIL aging_resume: got ld %b s %b want 1 0", ld_grant, if_starved); end
`else
    tests++; if (if_starved !== 1'b0 || ld_grant !== 1'b1 || if_grant !== 1'b0) begin fails++; $display("FAIL fixed_prio: got s %b ld %b if %b want 0 1 0", if_starved, ld_grant, if_grant); end
    step(); if_req = 0; settle();
`endif
    step(); ld_req = 0; step(); step(); step();
  endtask

  task automatic test_reset_mid();
    ld_req = 1; ld_addr = 32'h900; settle();
    tests++; if (ld_grant !== 1'b1) begin fails++; $display("FAIL rst_mid_grant: got %b want 1", ld_grant); end
    step(); reset = 1; st_req = 1; if_req = 1; settle();
    tests++; if ({st_grant, ld_grant, if_grant, mem_command} !== 5'b0) begin fails++; $display("FAIL rst_mid_quiet: got %b want 0", {st_grant, ld_grant, if_grant, mem_command}); end
    step(); mem_rdata = 64'hBAD; settle();
    tests++; if (ld_rsp_valid !== 1'b0 || ld_rsp_data !== 64'h0) begin fails++; $display("FAIL rst_mid_rsp: got v %b d %h want 0 0", ld_rsp_valid, ld_rsp_data); end
    step(); reset = 0; st_req = 0; ld_req = 0; if_req = 0; settle();
    tests++; if (ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_late: got %b want 0", ld_rsp_valid); end
    step(); settle();
    tests++; if (ld_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_late2: got %b want 0", ld_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_flush();
    test_aging();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between three requesters: store commit (ROB head), load buffer, and instruction fetch.
- Issues at most one memory command per cycle, with fixed priority store > load > fetch.
- Tracks in-flight reads with an owner-tag pipeline and routes read data back to the load buffer or fetch.
- Its per-requester grants replace the coarse commit_wr_mem/lb_read_mem stall signals currently fed to the hazard logic.

Parameters:
- ADDR_W, 32: memory address width.
- DATA_W, 64: memory data bus width.
- MEM_LATENCY, 2: cycles from command issue to mem_rdata valid; legal range >= 1.
- STARVE_LIMIT, 4: consecutive denied fetch cycles before fetch is promoted (AGING_EN only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- st_req  in  1  commit store wants port
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_size  in  2  store size (0 byte, 1 half, 2 word, 3 double)
- ld_req  in  1  load buffer wants port
- ld_addr  in  ADDR_W  load address
- ld_size  in  2  load size
- if_req  in  1  fetch wants port
- if_addr  in  ADDR_W  fetch address (always double size)
- if_flush  in  1  branch misprediction; kill fetch traffic
- st_grant  out  1  store issued this cycle
- ld_grant  out  1  load issued this cycle
- if_grant  out  1  fetch issued this cycle
- ld_rsp_valid  out  1  load data valid
- ld_rsp_data  out  DATA_W  load data
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  DATA_W  fetch data
- if_starved  out  1  fetch promotion active this cycle
- mem_command  out  2  0 NONE, 1 LOAD, 2 STORE
- mem_addr  out  ADDR_W  selected address
- mem_size  out  2  selected size
- mem_wdata  out  DATA_W  store data; 0 when not storing
- mem_rdata  in  DATA_W  read data, valid MEM_LATENCY cycles after a LOAD command

Behaviour:
- Grants are combinational in the request cycle.
  - Exactly one of st/ld/if_grant is high when any eligible request exists; otherwise none.
  - The mem_* outputs reflect the winner in the same cycle.
  - Requester holds req/addr stable until granted; grant means accepted.
- Eligible fetch = if_req & ~if_flush. A flushed cycle never grants fetch.
- Priority, normal: st > ld > if.
- Owner tag pipeline:
  - MEM_LATENCY stages, each {NONE, LD, IF}.
  - Stage 0 loads the granted read owner (STORE or idle loads NONE); stages shift each cycle.
  - When the last stage holds LD: ld_rsp_valid=1, ld_rsp_data=mem_rdata.
  - When the last stage holds IF: if_rsp_valid=1, if_rsp_data=mem_rdata.
  - Response data outputs are 0 when the matching valid is 0.
- Latency: read granted in cycle t -> rsp_valid in cycle t+MEM_LATENCY. Back-to-back grants are legal every cycle.
- Stores generate no response.
- if_flush:
  - Converts every IF tag in the pipeline to NONE at the clock edge.
  - If an IF tag reaches the last stage in the flush cycle, if_rsp_valid is forced 0 that cycle.
  - LD tags are unaffected.
- A new grant and a response in the same cycle are independent. No structural conflict.
- Reset:
  - Tags are cleared to NONE and the starvation counter to 0.
  - While reset is high, all grants, rsp_valids and if_starved are 0, and mem_command=NONE.
  - Reset mid-transaction drops outstanding reads silently; late mem_rdata is ignored.

Optional Feature:
- Macro: MEM_ARB_AGING_EN.
- Defined:
  - 3-bit saturating counter increments each cycle eligible fetch is denied, and clears on if_grant or if_flush.
  - When counter >= STARVE_LIMIT, if_starved=1 and priority becomes if > st > ld for that cycle. The counter clears on the resulting grant.
- Undefined: pure fixed priority, no counter, if_starved tied 0.

Test Plan:
- MEM_LATENCY=2. if_req alone, if_addr=0x100, mem_rdata=0xDEAD at t+2 -> if_grant at t, mem_command=1, if_rsp_valid and if_rsp_data=0xDEAD at t+2 only.
- st_req, ld_req and if_req all high in one cycle -> st_grant, mem_command=2, mem_wdata=st_data. Next cycle, with st_req low -> ld_grant.
- Loads granted at t and t+1, mem_rdata A then B -> ld_rsp_valid at t+2 (A) and t+3 (B).
- Fetch granted at t, if_flush at t+1 -> no if_rsp_valid at t+2. An interleaved load granted at t+1 still returns at t+3.
- MEM_ARB_AGING_EN, ld_req held high with if_req for 4 cycles -> 5th cycle if_starved=1 and if_grant=1; ld_grant resumes the cycle after.
- Reset asserted one cycle after a load grant -> no ld_rsp_valid afterward, all outputs 0 during reset.
